// File: rtl/cpu_pkg.sv
// cpu_pkg: op codes shared by the register bank ALU and the control decoder
package cpu_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
endpackage

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: combinational op unit (old, data, op -> result, carry, zero, flags_update)
module reg_bank_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] old,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             flags_update
);
  logic [WIDTH:0] ext, res;
  always_comb begin
    ext = {1'b0, old};
    res = ext;
    flags_update = 1'b1;
    case (op)
      OP_LOAD: res = {1'b0, data};
      OP_INC:  res = ext + (WIDTH+1)'(1);
      OP_DEC:  res = ext - (WIDTH+1)'(1);
      OP_SHL:  res = ext << 1;
      // shifted-out lsb is parked in the carry bit
      OP_SHR:  res = {old[0], 1'b0, old[WIDTH-1:1]};
      OP_CLR:  res = '0;
      default: flags_update = 1'b0;
    endcase
    result = res[WIDTH-1:0];
    carry = res[WIDTH];
    zero = result == '0;
  end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank (clk, rst, data, wrAddr, op, rdAddr, outputEnable -> dataOut, outValid, zeroFlag, carryFlag)
module reg_bank
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic              outputEnable,
  output logic [WIDTH-1:0]  dataOut,
  output logic              outValid,
  output logic              zeroFlag,
  output logic              carryFlag
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] old_val, new_val, rd_val;
  logic wr_ok, rd_ok, carry, zero, upd;
  always_comb begin
    wr_ok = 32'(wrAddr) < DEPTH;
    rd_ok = 32'(rdAddr) < DEPTH;
    old_val = wr_ok ? regs[wrAddr] : '0;
    rd_val = rd_ok ? regs[rdAddr] : '0;
  end
  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .old(old_val),
    .data(data),
    .op(op),
    .result(new_val),
    .carry(carry),
    .zero(zero),
    .flags_update(upd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      dataOut <= '0;
      outValid <= 1'b0;
      zeroFlag <= 1'b0;
      carryFlag <= 1'b0;
    end else begin
      if (wr_ok && upd) begin
        regs[wrAddr] <= new_val;
        zeroFlag <= zero;
        carryFlag <= carry;
      end
      if (outputEnable) dataOut <= rd_val;
      outValid <= outputEnable;
    end
  end
endmodule
